fixed_point_accumulator: RTL and testbench

//  Downstream consumer of the signed 16x16 fixed-point multiplier. Takes its 32-bit product,

---
 rtl/fxp_pkg.sv | 25 ++
 rtl/fxp_round_sat.sv | 39 +++
 rtl/fixed_point_accumulator.sv | 116 +++++++++++
 tb/tb_fixed_point_accumulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point solver datapath.
//   FRAC_BITS_DEF : default number of fractional bits in the Q8.8 output
//   Q_MAX / Q_MIN : Q8.8 saturation limits
//   acc_state_t   : accumulator FSM states
//   acc_w_ok      : elaboration check that an accumulator of a given width
//                   cannot wrap for the given maximum row length
package fxp_pkg;

  localparam int unsigned FRAC_BITS_DEF = 8;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic bit acc_w_ok(input int unsigned acc_w,
                                  input int unsigned max_terms);
    return acc_w >= (32 + $clog2(max_terms));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round / shift / saturate from an ACC_W-bit signed sum to a
// 16-bit signed fixed-point result.
//   sum  : signed accumulator value, FRAC_BITS*2 fractional bits
//   data : round-half-toward-+inf of sum >>> FRAC_BITS, clipped to 16 bits
//   sat  : data was clipped to Q_MAX or Q_MIN
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [15:0]      data,
  output logic                    sat
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] HALF   = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACC_W:0] LIM_HI = {{(ACC_W-14){1'b0}}, 15'h7FFF};
  localparam logic signed [ACC_W:0] LIM_LO = ~LIM_HI;

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    biased  = $signed({sum[ACC_W-1], sum}) + HALF;
    shifted = biased >>> FRAC_BITS;
    data    = shifted[15:0];
    sat     = 1'b0;
    if (shifted > LIM_HI) begin
      data = Q_MAX;
      sat  = 1'b1;
    end else if (shifted < LIM_LO) begin
      data = Q_MIN;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Row accumulator for the signed 16x16 multiplier output. Sums the 32-bit
// products of one row and returns one rounded, saturated Q8.8 result per row.
//   clock, aclr        : rising-edge clock, synchronous active-high reset
//   prod_hi, prod_lo   : product bits [31:16] and [15:0]
//   in_valid, in_last  : term present / final term of the row
//   in_ready           : term accepted when in_valid && in_ready
//   out_data, out_sat  : row result and clip flag
//   out_valid, out_ready : result handshake, result held until taken
//   err_len            : sticky, a row ran past MAX_TERMS terms
module fixed_point_accumulator
  import fxp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned MAX_TERMS = 256,
  parameter int unsigned ACC_W     = 40
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic [15:0] prod_hi,
  input  logic [15:0] prod_lo,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_len
);

  localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (!acc_w_ok(ACC_W, MAX_TERMS)) begin : g_acc_w_check
    $error("ACC_W too narrow for MAX_TERMS");
  end
  if (FRAC_BITS < 1 || FRAC_BITS > 15) begin : g_frac_check
    $error("FRAC_BITS must be in 1..15");
  end

  acc_state_t state, state_n;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_new;
  logic        [CNT_W-1:0] count;
  logic                    accept;
  logic                    take;
  logic                    first;
  logic        [15:0]      rs_data;
  logic                    rs_sat;

  assign prod_ext  = ACC_W'($signed({prod_hi, prod_lo}));
  assign out_valid = (state == HOLD);
  assign in_ready  = !aclr && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  // IDLE and HOLD both mean no partial sum is open, so the term starts a row.
  assign first     = (state != ACCUM);
  assign sum_new   = first ? prod_ext : acc + prod_ext;

  fxp_round_sat #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .sum  (sum_new),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_n = HOLD;
      end
      HOLD: begin
        // In HOLD a term can only be accepted when the result is also taken.
        if (accept)    state_n = in_last ? HOLD : ACCUM;
        else if (take) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= sum_new;
        if (first)                count <= CNT_ONE;
        else if (count != CNT_MAX) count <= count + CNT_ONE;
        if (!first && !in_last && count == CNT_MAX) err_len <= 1'b1;
      end
      if (accept && in_last) begin
        out_data <= rs_data;
        out_sat  <= rs_sat;
      end else if (take) begin
        out_data <= '0;
        out_sat  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboard bench for fixed_point_accumulator (FRAC_BITS=8, MAX_TERMS=256).
module tb_fixed_point_accumulator;

  localparam int unsigned MAX_TERMS = 256;

  logic        clock = 1'b0;
  logic        aclr;
  logic [15:0] prod_hi, prod_lo;
  logic        in_valid, in_last, in_ready;
  logic [15:0] out_data;
  logic        out_sat, out_valid, out_ready, err_len;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] sb[$];

  always #5 clock = ~clock;

  fixed_point_accumulator #(
    .FRAC_BITS (8),
    .MAX_TERMS (MAX_TERMS),
    .ACC_W     (40)
  ) dut (
    .clock     (clock),
    .aclr      (aclr),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_len   (err_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: round half toward +inf of s/256, clip to 16 bits. Returns {sat,data}.
  function automatic logic [16:0] model(input longint s);
    longint r;
    r = (s + 128) >>> 8;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(r)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the term was accepted.
  task automatic send(input logic [31:0] p, input logic last, input logic [16:0] exp);
    logic acc_seen;
    int   n;
    {prod_hi, prod_lo} = p;
    in_valid = 1'b1;
    in_last  = last;
    acc_seen = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      acc_seen = in_ready;
      step();
      n++;
    end while (!acc_seen && n < 200);
    if (!acc_seen) check("accept_timeout", 32'd0, 32'd1);
    else if (last) sb.push_back(exp);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!aclr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {16'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
        check("out_sat", {31'd0, out_sat}, {31'd0, e[16]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    int     nt;
    logic [31:0] p;

    aclr = 1'b1; prod_hi = '0; prod_lo = '0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
    step();
    aclr = 1'b0;

    // Single term, 1-cycle latency.
    send(32'h0003_0000, 1'b1, {1'b0, 16'h0300});
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_out_data", {16'd0, out_data}, 32'h0000_0300);

    // Multi-term row and rounding boundaries.
    send(32'h0003_0000, 1'b0, '0);
    send(32'hFFFF_0000, 1'b0, '0);
    send(32'h0000_8000, 1'b1, {1'b0, 16'h0280});
    send(32'h0000_0080, 1'b1, {1'b0, 16'h0001});
    send(32'h0000_007F, 1'b1, {1'b0, 16'h0000});

    // Saturation both ways.
    send(32'h7FFF_0000, 1'b1, {1'b1, 16'h7FFF});
    send(32'h8000_0000, 1'b1, {1'b1, 16'h8000});
    step();

    // Backpressure, then drain and new row in the same cycle.
    out_ready = 1'b0;
    send(32'h0002_0000, 1'b1, {1'b0, 16'h0200});
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {16'd0, out_data}, 32'h0000_0200);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1'b1;
    send(32'h0001_0000, 1'b1, {1'b0, 16'h0100});
    check("bp_new_row", {16'd0, out_data}, 32'h0000_0100);
    repeat (3) step();

    // Reset mid-row discards the partial sum.
    send(32'h0005_0000, 1'b0, '0);
    send(32'h0006_0000, 1'b0, '0);
    aclr = 1'b1;
    step();
    @(negedge clock);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    step();
    aclr = 1'b0;
    send(32'h0001_0000, 1'b1, {1'b0, 16'h0100});
    repeat (2) step();

    // Row length error.
    for (int i = 0; i < MAX_TERMS; i++) send(32'h0000_0100, 1'b0, '0);
    check("len_no_err_at_max", {31'd0, err_len}, 32'd0);
    send(32'h0000_0100, 1'b0, '0);
    check("len_err_set", {31'd0, err_len}, 32'd1);
    send(32'h0000_0100, 1'b1, {1'b0, 16'h0102});
    send(32'h0001_0000, 1'b1, {1'b0, 16'h0100});
    check("len_err_sticky", {31'd0, err_len}, 32'd1);
    repeat (2) step();
    aclr = 1'b1;
    step();
    aclr = 1'b0;
    check("len_err_cleared", {31'd0, err_len}, 32'd0);

    // Random rows with idle gaps.
    for (int r = 0; r < 8; r++) begin
      nt = $urandom_range(1, 6);
      s  = 0;
      for (int t = 0; t < nt; t++) begin
        p = $urandom;
        if ($urandom_range(0, 3) != 0) p = 32'($signed(p) >>> 8);
        s += longint'($signed(p));
        send(p, (t == nt - 1), model(s));
        if ($urandom_range(0, 2) == 0) step();
      end
    end

    repeat (5) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
